// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX,
        ALUWB, BEQEX, ADDIEX, ORIEX, IMMWB, JEX
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // Full per-cycle control word driven into the datapath.
    typedef struct packed {
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       zeroext;
        logic [1:0] aluop;
        logic       memwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
               (op == OP_ADDI) || (op == OP_J) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// State -> control-word lookup for the multicycle controller.
// Latency: purely combinational.
// Backpressure: mem_ready gates the FETCH IR/PC load and the MEMWR completion pulse.
//  Ports: state (current FSM state), op (opcode, legality in DECODE),
//         mem_ready (memory handshake), ctrl (control word out).
module mc_ctrl_decode
    import mips_pkg::*;
#(
    parameter int OPW = 6
) (
    input  state_t         state,
    input  logic [OPW-1:0] op,
    input  logic           mem_ready,
    output ctrl_t          ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.irwrite = mem_ready;
                ctrl.pcwrite = mem_ready;
            end
            DECODE: begin
                // Branch target is precomputed into ALUOut here for BEQEX.
                ctrl.alusrcb = SRCB_IMMSH;
                if (!op_legal(op)) begin
                    ctrl.illegal_op = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
            end
            MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            MEMRD: ctrl.iord = 1'b1;
            MEMWB: begin
                ctrl.memtoreg   = 1'b1;
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEMWR: begin
                // Write strobe held until the memory acknowledges.
                ctrl.iord       = 1'b1;
                ctrl.memwrite   = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                ctrl.regdst     = 1'b1;
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            BEQEX: begin
                ctrl.alusrca    = 1'b1;
                ctrl.aluop      = ALUOP_SUB;
                ctrl.branch     = 1'b1;
                ctrl.pcsrc      = PCSRC_ALUOUT;
                ctrl.instr_done = 1'b1;
            end
            ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            ORIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.zeroext = 1'b1;
                ctrl.aluop   = ALUOP_OR;
            end
            IMMWB: begin
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            JEX: begin
                ctrl.pcsrc      = PCSRC_JUMP;
                ctrl.pcwrite    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Moore FSM sequencing the shared multicycle MIPS datapath.
// Latency: outputs follow state combinationally; 3-5 cycles per instruction plus memory waits.
// Backpressure: FETCH, MEMRD and MEMWR hold until mem_ready.
//  Ports: clk, reset_n (sync active-low), op, mem_ready in; datapath selects,
//         write enables, instr_done and illegal_op out.
module mc_controller
    import mips_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [OPW-1:0] op,
    input  logic           mem_ready,
    output logic           iord,
    output logic           irwrite,
    output logic           pcwrite,
    output logic           branch,
    output logic [1:0]     pcsrc,
    output logic           alusrca,
    output logic [1:0]     alusrcb,
    output logic           zeroext,
    output logic [1:0]     aluop,
    output logic           memwrite,
    output logic           memtoreg,
    output logic           regdst,
    output logic           regwrite,
    output logic           instr_done,
    output logic           illegal_op
);

    state_t state;
    state_t nxt;
    ctrl_t  ctrl;

    mc_ctrl_decode #(.OPW(OPW)) u_decode (
        .state     (state),
        .op        (op),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    always_comb begin
        nxt = state;
        case (state)
            FETCH:   if (mem_ready) nxt = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_RTYPE:     nxt = RTYPEEX;
                    OP_BEQ:       nxt = BEQEX;
                    OP_ADDI:      nxt = ADDIEX;
                    OP_ORI:       nxt = ORIEX;
                    OP_J:         nxt = JEX;
                    default:      nxt = FETCH;
                endcase
            end
            MEMADR:  nxt = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   if (mem_ready) nxt = MEMWB;
            MEMWR:   if (mem_ready) nxt = FETCH;
            RTYPEEX: nxt = ALUWB;
            ADDIEX:  nxt = IMMWB;
            ORIEX:   nxt = IMMWB;
            default: nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= FETCH;
        else          state <= nxt;
    end

    // Selects pass through; anything that changes architectural state is
    // suppressed while reset is held, even mid-instruction.
    assign iord       = ctrl.iord;
    assign pcsrc      = ctrl.pcsrc;
    assign alusrca    = ctrl.alusrca;
    assign alusrcb    = ctrl.alusrcb;
    assign zeroext    = ctrl.zeroext;
    assign aluop      = ctrl.aluop;
    assign memtoreg   = ctrl.memtoreg;
    assign regdst     = ctrl.regdst;
    assign irwrite    = ctrl.irwrite    & reset_n;
    assign pcwrite    = ctrl.pcwrite    & reset_n;
    assign branch     = ctrl.branch     & reset_n;
    assign memwrite   = ctrl.memwrite   & reset_n;
    assign regwrite   = ctrl.regwrite   & reset_n;
    assign instr_done = ctrl.instr_done & reset_n;
    assign illegal_op = ctrl.illegal_op & reset_n;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller with an instruction-level expected-trace model.
// Latency: n/a.
// Backpressure: mem_ready wait cycles injected per test.
module tb_mc_controller;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                           BQ = 6'b000100, AI = 6'b001000, JJ = 6'b000010,
                           OR = 6'b001101, BAD = 6'b111111;

    typedef struct packed {
        logic       iord, irwrite, pcwrite, branch;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       zeroext;
        logic [1:0] aluop;
        logic       memwrite, memtoreg, regdst, regwrite, instr_done, illegal_op;
    } outv_t;

    typedef struct packed {
        logic       rst_n;
        logic       rdy;
        logic [5:0] op;
        outv_t      exp;
    } cyc_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic mem_ready = 1'b0;
    logic iord, irwrite, pcwrite, branch, alusrca, zeroext;
    logic memwrite, memtoreg, regdst, regwrite, instr_done, illegal_op;
    logic [1:0] pcsrc, alusrcb, aluop;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
        .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite), .branch(branch),
        .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb), .zeroext(zeroext),
        .aluop(aluop), .memwrite(memwrite), .memtoreg(memtoreg), .regdst(regdst),
        .regwrite(regwrite), .instr_done(instr_done), .illegal_op(illegal_op)
    );

    outv_t got;
    assign got = {iord, irwrite, pcwrite, branch, pcsrc, alusrca, alusrcb, zeroext,
                  aluop, memwrite, memtoreg, regdst, regwrite, instr_done, illegal_op};

    cyc_t  q[$];
    int    lat_q[$];
    outv_t exp_v;
    logic  chk = 1'b0;
    int    vectors = 0;
    int    miscompares = 0;
    int    cnt = 0;
    int    memwrite_cycles = 0;
    int    illegal_pulses = 0;
    int    cyc_no = 0;

    // ---------------- model: per-step control values ----------------
    function automatic logic [5:0] garbage_op();
        return 6'($urandom);
    endfunction

    function automatic logic any_rdy();
        return 1'($urandom);
    endfunction

    // Queue one cycle; write-type outputs vanish while reset is held.
    task automatic add(input logic rst_n, input logic rdy, input logic [5:0] o, input outv_t e);
        cyc_t c;
        if (!rst_n) begin
            e.irwrite = 0; e.pcwrite = 0; e.branch = 0; e.memwrite = 0;
            e.regwrite = 0; e.instr_done = 0; e.illegal_op = 0;
        end
        c.rst_n = rst_n; c.rdy = rdy; c.op = o; c.exp = e;
        q.push_back(c);
    endtask

    function automatic outv_t v_fetch(input logic rdy);
        outv_t e = '0;
        e.alusrcb = 2'b01; e.irwrite = rdy; e.pcwrite = rdy;
        return e;
    endfunction

    function automatic outv_t v_addr();
        outv_t e = '0;
        e.alusrca = 1; e.alusrcb = 2'b10;
        return e;
    endfunction

    // Expand one instruction into its expected cycle trace.
    // fw: FETCH wait cycles; mw: memory wait cycles in MEMRD/MEMWR.
    task automatic build(input logic [5:0] o, input int fw, input int mw);
        outv_t e;
        for (int i = 0; i < fw; i++) add(1, 0, garbage_op(), v_fetch(0));
        add(1, 1, garbage_op(), v_fetch(1));
        e = '0; e.alusrcb = 2'b11;
        if (!(o inside {LW, SW, RT, BQ, AI, JJ, OR})) begin
            e.illegal_op = 1; e.instr_done = 1;
            add(1, any_rdy(), o, e);
            return;
        end
        add(1, any_rdy(), o, e);
        case (o)
            LW: begin
                add(1, any_rdy(), o, v_addr());
                e = '0; e.iord = 1;
                for (int i = 0; i < mw; i++) add(1, 0, garbage_op(), e);
                add(1, 1, garbage_op(), e);
                e = '0; e.memtoreg = 1; e.regwrite = 1; e.instr_done = 1;
                add(1, any_rdy(), garbage_op(), e);
            end
            SW: begin
                add(1, any_rdy(), o, v_addr());
                e = '0; e.iord = 1; e.memwrite = 1;
                for (int i = 0; i < mw; i++) add(1, 0, garbage_op(), e);
                e.instr_done = 1;
                add(1, 1, garbage_op(), e);
            end
            RT: begin
                e = '0; e.alusrca = 1; e.aluop = 2'b10;
                add(1, any_rdy(), garbage_op(), e);
                e = '0; e.regdst = 1; e.regwrite = 1; e.instr_done = 1;
                add(1, any_rdy(), garbage_op(), e);
            end
            AI, OR: begin
                e = v_addr();
                if (o == OR) begin e.zeroext = 1; e.aluop = 2'b11; end
                add(1, any_rdy(), garbage_op(), e);
                e = '0; e.regwrite = 1; e.instr_done = 1;
                add(1, any_rdy(), garbage_op(), e);
            end
            BQ: begin
                e = '0; e.alusrca = 1; e.aluop = 2'b01; e.branch = 1;
                e.pcsrc = 2'b01; e.instr_done = 1;
                add(1, any_rdy(), garbage_op(), e);
            end
            default: begin
                e = '0; e.pcsrc = 2'b10; e.pcwrite = 1; e.instr_done = 1;
                add(1, any_rdy(), garbage_op(), e);
            end
        endcase
    endtask

    task automatic play();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge clk);
            reset_n = c.rst_n; mem_ready = c.rdy; op = c.op; exp_v = c.exp; chk = 1'b1;
        end
    endtask

    // lat: hand-computed instruction length, checked against DUT instr_done spacing.
    task automatic run(input logic [5:0] o, input int fw, input int mw, input int lat);
        build(o, fw, mw);
        lat_q.push_back(lat);
        play();
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        #2;
        if (chk) begin
            cyc_no++;
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL ctrl cycle %0d: got %05h want %05h", cyc_no, got, exp_v);
            end
            if (memwrite === 1'b1) memwrite_cycles++;
            if (illegal_op === 1'b1) illegal_pulses++;
            if (!reset_n) cnt = 0;
            else begin
                cnt++;
                if (instr_done === 1'b1) begin
                    vectors++;
                    if (lat_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL latency cycle %0d: unexpected instr_done after %0d cycles", cyc_no, cnt);
                    end else begin
                        if (cnt != lat_q[0]) begin
                            miscompares++;
                            $display("FAIL latency cycle %0d: got %0d want %0d", cyc_no, cnt, lat_q[0]);
                        end
                        void'(lat_q.pop_front());
                    end
                    cnt = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        outv_t e;
        // Reset with mem_ready high: FETCH selects visible, IR/PC loads masked.
        @(negedge clk); reset_n = 0; mem_ready = 1; op = 0;
        add(0, 1, garbage_op(), v_fetch(1));
        play();

        run(LW, 0, 0, 5);
        run(SW, 0, 3, 7);
        run(RT, 0, 0, 4);
        run(AI, 0, 0, 4);
        run(OR, 0, 0, 4);
        run(BQ, 0, 0, 3);
        run(JJ, 0, 0, 3);
        run(BAD, 0, 0, 2);
        run(AI, 2, 0, 6);
        run(LW, 1, 2, 8);

        // Reset while LW waits in MEMRD; mem_ready high must not reach MEMWB.
        add(1, 1, garbage_op(), v_fetch(1));
        e = '0; e.alusrcb = 2'b11;
        add(1, 0, LW, e);
        add(1, 0, LW, v_addr());
        e = '0; e.iord = 1;
        add(1, 0, garbage_op(), e);
        add(1, 0, garbage_op(), e);
        add(0, 1, garbage_op(), e);
        play();
        run(JJ, 0, 0, 3);

        @(negedge clk); chk = 1'b0;
        #3;
        vectors++;
        if (lat_q.size() != 0) begin
            miscompares++;
            $display("FAIL done_count: %0d instructions never completed, want 0", lat_q.size());
        end
        vectors++;
        if (memwrite_cycles != 4) begin
            miscompares++;
            $display("FAIL memwrite_cycles: got %0d want 4", memwrite_cycles);
        end
        vectors++;
        if (illegal_pulses != 1) begin
            miscompares++;
            $display("FAIL illegal_pulses: got %0d want 1", illegal_pulses);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
